// File: rtl/repairclk_pattern_detector_if.sv
// Bundle between the REPAIRCLK partner and the clock/track pattern detector:
// clear request, synchronized lane samples, and the logged detection result.
interface repairclk_pattern_detector_if;
  logic       i_clear_clk_detection;
  logic       i_RCKP;
  logic       i_RCKN;
  logic       i_RTRK;
  logic [2:0] o_Clock_track_result_logged;
  logic       o_result_valid;
  logic       o_detect_active;

  modport master (
    output i_clear_clk_detection, i_RCKP, i_RCKN, i_RTRK,
    input  o_Clock_track_result_logged, o_result_valid, o_detect_active
  );

  modport slave (
    input  i_clear_clk_detection, i_RCKP, i_RCKN, i_RTRK,
    output o_Clock_track_result_logged, o_result_valid, o_detect_active
  );
endinterface

// File: rtl/repairclk_pattern_detector.sv
// Detects the REPAIRCLK iteration pattern (toggle burst then low run) on the
// RCKP/RCKN/RTRK lanes within a timed window and logs a sticky per-lane result.
module repairclk_pattern_detector #(
  parameter int unsigned HI_LEN        = 16,
  parameter int unsigned LO_LEN        = 8,
  parameter int unsigned DETECT_THRESH = 16,
  parameter int unsigned WINDOW        = 3200
) (
  input  logic                         CLK,
  input  logic                         rst,
  repairclk_pattern_detector_if.slave  bus
);

  localparam int unsigned NL      = 3;
  localparam int unsigned WW      = $clog2(WINDOW);
  localparam int unsigned POS_MAX = (HI_LEN > LO_LEN) ? HI_LEN - 1 : LO_LEN - 1;
  localparam int unsigned PW      = $clog2(POS_MAX + 1);
  localparam int unsigned CW      = $clog2(DETECT_THRESH + 1);

  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [PW-1:0] HI_LAST  = PW'(HI_LEN - 1);
  localparam logic [PW-1:0] LO_LAST  = PW'(LO_LEN - 1);
  localparam logic [CW-1:0] THRESH   = CW'(DETECT_THRESH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  typedef enum logic [1:0] {L_IDLE, L_HI, L_LO} lane_state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   win_q, win_d;
  logic [NL-1:0]   res_q, res_d;
  lane_state_t     ls_q[NL], ls_d[NL];
  logic [PW-1:0]   pos_q[NL], pos_d[NL];
  logic [CW-1:0]   consec_q[NL], consec_d[NL];
  logic [NL-1:0]   lane_in;

  assign lane_in = {bus.i_RTRK, bus.i_RCKN, bus.i_RCKP};

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    res_d   = res_q;
    for (int unsigned i = 0; i < NL; i++) begin
      ls_d[i]     = ls_q[i];
      pos_d[i]    = pos_q[i];
      consec_d[i] = consec_q[i];
    end

    case (state_q)
      IDLE: ;
      ACTIVE: begin
        if (win_q == WIN_LAST) state_d = DONE;
        else                   win_d   = win_q + WW'(1);

        for (int unsigned i = 0; i < NL; i++) begin
          case (ls_q[i])
            L_IDLE: begin
              if (lane_in[i]) begin
                ls_d[i]  = L_HI;
                pos_d[i] = PW'(1);
              end
            end
            L_HI: begin
              // Toggle burst expects 1 on even positions, 0 on odd ones.
              if (lane_in[i] == ~pos_q[i][0]) begin
                if (pos_q[i] == HI_LAST) begin
                  ls_d[i]  = L_LO;
                  pos_d[i] = '0;
                end else begin
                  pos_d[i] = pos_q[i] + PW'(1);
                end
              end else begin
                consec_d[i] = '0;
                if (lane_in[i]) begin
                  ls_d[i]  = L_HI;
                  pos_d[i] = PW'(1);
                end else begin
                  ls_d[i]  = L_IDLE;
                  pos_d[i] = '0;
                end
              end
            end
            L_LO: begin
              if (!lane_in[i]) begin
                if (pos_q[i] == LO_LAST) begin
                  consec_d[i] = (consec_q[i] == THRESH) ? consec_q[i] : consec_q[i] + CW'(1);
                  ls_d[i]     = L_HI;
                  pos_d[i]    = '0;
                end else begin
                  pos_d[i] = pos_q[i] + PW'(1);
                end
              end else begin
                consec_d[i] = '0;
                ls_d[i]     = L_HI;
                pos_d[i]    = PW'(1);
              end
            end
            default: begin
              ls_d[i]  = L_IDLE;
              pos_d[i] = '0;
            end
          endcase
          if (consec_d[i] == THRESH) res_d[i] = 1'b1;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // A clear overrides everything above, including window expiry.
    if (bus.i_clear_clk_detection) begin
      state_d = ACTIVE;
      win_d   = '0;
      res_d   = '0;
      for (int unsigned i = 0; i < NL; i++) begin
        ls_d[i]     = L_IDLE;
        pos_d[i]    = '0;
        consec_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      res_q   <= '0;
      for (int unsigned i = 0; i < NL; i++) begin
        ls_q[i]     <= L_IDLE;
        pos_q[i]    <= '0;
        consec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      res_q   <= res_d;
      for (int unsigned i = 0; i < NL; i++) begin
        ls_q[i]     <= ls_d[i];
        pos_q[i]    <= pos_d[i];
        consec_q[i] <= consec_d[i];
      end
    end
  end

  assign bus.o_Clock_track_result_logged = res_q;
  assign bus.o_result_valid              = (state_q == DONE);
  assign bus.o_detect_active             = (state_q == ACTIVE);

endmodule
